// File: rtl/hamming_decoder.sv
// Extended Hamming (16,11) SECDED decoder: takes the codeword as two bytes, then delivers corrected data and status.
// Optional error statistics counters are built when DECODER_STATS_EN is defined.
module hamming_decoder (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [10:0] out_data,
  output logic [1:0]  out_status,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  corr_cnt,
  output logic [7:0]  dbl_cnt
);

  localparam logic [1:0] GET_LO = 2'd0;
  localparam logic [1:0] GET_HI = 2'd1;
  localparam logic [1:0] CALC   = 2'd2;
  localparam logic [1:0] SEND   = 2'd3;

  localparam logic [1:0] ST_CLEAN = 2'b00;
  localparam logic [1:0] ST_CORR  = 2'b01;
  localparam logic [1:0] ST_DBL   = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [7:0]  lsw_q, msw_q;
  logic [10:0] data_q, data_d;
  logic [1:0]  status_q, status_d;
  logic [15:0] word;
  logic [3:0]  syn;
  logic        pe;
  logic        xfer, deliver;

  // Gated by reset so the block never advertises readiness while held in reset.
  assign in_ready  = Reset_n && (state_q == GET_LO || state_q == GET_HI);
  assign xfer      = in_valid && in_ready;
  assign out_valid = (state_q == SEND);
  assign deliver   = out_valid && out_ready;
  assign out_data   = data_q;
  assign out_status = status_q;
  assign word = {msw_q, lsw_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      GET_LO:  if (xfer) state_d = GET_HI;
      GET_HI:  if (xfer) state_d = CALC;
      CALC:    state_d = SEND;
      SEND:    if (out_ready) state_d = GET_LO;
      default: state_d = GET_LO;
    endcase
  end

  // Syndrome bit n is the parity of every position whose index has bit n set.
  always_comb begin
    syn = '0;
    for (int k = 0; k < 16; k++)
      for (int n = 0; n < 4; n++)
        if (k[n]) syn[n] = syn[n] ^ word[k];
    pe = ^word;
  end

  // Data bits sit at the non-power-of-two positions; each is flipped if it is the located error.
  always_comb begin
    int j;
    status_d = status_q;
    data_d   = data_q;
    j = 0;
    if (state_q == CALC) begin
      if (pe)
        status_d = ST_CORR;
      else if (syn != 4'd0)
        status_d = ST_DBL;
      else
        status_d = ST_CLEAN;
      for (int k = 3; k < 16; k++) begin
        if ((k & (k - 1)) != 0) begin
          data_d[j] = word[k] ^ (pe && (syn == k[3:0]));
          j = j + 1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= GET_LO;
      lsw_q    <= '0;
      msw_q    <= '0;
      data_q   <= '0;
      status_q <= ST_CLEAN;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      status_q <= status_d;
      if (xfer && state_q == GET_LO) lsw_q <= in_byte;
      if (xfer && state_q == GET_HI) msw_q <= in_byte;
    end
  end

`ifdef DECODER_STATS_EN
  logic [7:0] corr_q, dbl_q;

  // Counted at the consumer handshake so each delivered result is counted once.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      corr_q <= '0;
      dbl_q  <= '0;
    end else if (deliver) begin
      if (status_q == ST_CORR && corr_q != 8'hFF) corr_q <= corr_q + 8'd1;
      if (status_q == ST_DBL  && dbl_q  != 8'hFF) dbl_q  <= dbl_q + 8'd1;
    end
  end

  assign corr_cnt = corr_q;
  assign dbl_cnt  = dbl_q;
`else
  logic unused_deliver;
  assign unused_deliver = deliver;
  assign corr_cnt = '0;
  assign dbl_cnt  = '0;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Bench for hamming_decoder: fixed vector table, reset sequences, and random encoded words
// with 0/1/2 injected bit errors checked against a positional SECDED model.
module tb_hamming_decoder;
  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] out_data;
  logic [1:0]  out_status;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  corr_cnt;
  logic [7:0]  dbl_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_corr = 0;
  int exp_dbl = 0;

  hamming_decoder dut (
    .Clk(Clk), .Reset_n(Reset_n), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_status(out_status),
    .out_valid(out_valid), .out_ready(out_ready), .corr_cnt(corr_cnt), .dbl_cnt(dbl_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  lsw;
    logic [7:0]  msw;
    logic [10:0] data;
    logic [1:0]  st;
    int          hold;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_data_pos(input int k);
    return (k != 0) && ((k & (k - 1)) != 0);
  endfunction

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w = '0;
    int j = 0;
    for (int k = 0; k < 16; k++)
      if (is_data_pos(k)) begin w[k] = d[j]; j++; end
    for (int n = 0; n < 4; n++) begin
      logic p = 1'b0;
      for (int k = 0; k < 16; k++) if ((k >> n) & 1) p ^= w[k];
      w[1 << n] = p;
    end
    w[0] = ^w;
    return w;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] w);
    logic [10:0] d = '0;
    int j = 0;
    for (int k = 0; k < 16; k++)
      if (is_data_pos(k)) begin d[j] = w[k]; j++; end
    return d;
  endfunction

  task automatic chk_counts(input string name);
`ifdef DECODER_STATS_EN
    chk({name, "_corr_cnt"}, 32'(corr_cnt), 32'(exp_corr));
    chk({name, "_dbl_cnt"},  32'(dbl_cnt),  32'(exp_dbl));
`else
    chk({name, "_corr_cnt"}, 32'(corr_cnt), 32'd0);
    chk({name, "_dbl_cnt"},  32'(dbl_cnt),  32'd0);
`endif
  endtask

  // Called #1 after a rising edge with the DUT idle in GET_LO.
  task automatic run_word(input logic [7:0] lsw, input logic [7:0] msw, input logic [10:0] ed,
                          input logic [1:0] est, input int hold, input int gap);
    int cyc;
    in_byte = lsw; in_valid = 1'b1; out_ready = 1'b0;
    cyc = 0;
    while (!in_ready && cyc < 8) begin @(posedge Clk); #1; cyc++; end
    chk("lsw_ready", 32'(in_ready), 32'd1);
    @(posedge Clk); #1;
    in_valid = 1'b0; in_byte = 8'h5A;
    for (int g = 0; g < gap; g++) begin @(posedge Clk); #1; end
    in_byte = msw; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (cyc <= 10) begin
      @(negedge Clk);
      if (out_valid) break;
      chk("calc_in_ready", 32'(in_ready), 32'd0);
      @(posedge Clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd2);
    chk("out_data", 32'(out_data), 32'(ed));
    chk("out_status", 32'(out_status), 32'(est));
    for (int h = 0; h < hold; h++) begin
      @(posedge Clk); #1;
      @(negedge Clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_data", 32'(out_data), 32'(ed));
      chk("hold_status", 32'(out_status), 32'(est));
    end
    @(posedge Clk); #1;
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    if (est == 2'b01 && exp_corr < 255) exp_corr++;
    if (est == 2'b10 && exp_dbl < 255) exp_dbl++;
    @(negedge Clk);
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_data_held", 32'(out_data), 32'(ed));
    chk("post_status_held", 32'(out_status), 32'(est));
    chk_counts("post");
    @(posedge Clk); #1;
  endtask

  task automatic pulse_reset_check(input string name);
    Reset_n = 1'b0;
    #2;
    chk({name, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_out_data"}, 32'(out_data), 32'd0);
    chk({name, "_out_status"}, 32'(out_status), 32'd0);
    exp_corr = 0; exp_dbl = 0;
    chk_counts(name);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic [10:0] d, ed;
    logic [1:0]  est;
    int ne, p1, p2, cyc;

    tbl[0] = '{8'hFF, 8'hFF, 11'h7FF, 2'b00, 0};
    tbl[1] = '{8'h20, 8'h00, 11'h000, 2'b01, 0};
    tbl[2] = '{8'h00, 8'h80, 11'h000, 2'b01, 0};
    tbl[3] = '{8'h01, 8'h00, 11'h000, 2'b01, 0};
    tbl[4] = '{8'h03, 8'h00, 11'h000, 2'b10, 0};
    tbl[5] = '{8'h00, 8'h00, 11'h000, 2'b00, 1};
    tbl[6] = '{8'h0F, 8'h00, 11'h001, 2'b00, 3};
    tbl[7] = '{8'h0F, 8'h01, 11'h001, 2'b01, 0};
    tbl[8] = '{8'h0F, 8'h03, 11'h011, 2'b10, 2};

    Reset_n = 1'b0; in_byte = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    #7;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_status", 32'(out_status), 32'd0);
    chk_counts("rst");
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    foreach (tbl[i]) run_word(tbl[i].lsw, tbl[i].msw, tbl[i].data, tbl[i].st, tbl[i].hold, i % 2);

    // Reset after only the low byte: partial word must be discarded.
    in_byte = 8'h00; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    pulse_reset_check("rst_mid");
    run_word(8'hFF, 8'hFF, 11'h7FF, 2'b00, 0, 0);

    // Reset while a result is pending in SEND.
    in_byte = 8'h20; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_byte = 8'h00;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 10) begin @(posedge Clk); #1; cyc++; end
    chk("send_before_rst", 32'(out_valid), 32'd1);
    pulse_reset_check("rst_send");
    run_word(8'hFF, 8'hFF, 11'h7FF, 2'b00, 0, 0);

    for (int i = 0; i < 40; i++) begin
      d  = 11'($urandom);
      w  = encode(d);
      ne = $urandom_range(0, 2);
      p1 = $urandom_range(0, 15);
      p2 = (p1 + $urandom_range(1, 15)) % 16;
      if (ne >= 1) w[p1] = ~w[p1];
      if (ne == 2) w[p2] = ~w[p2];
      ed  = (ne == 2) ? extract(w) : d;
      est = 2'(ne);
      run_word(w[7:0], w[15:8], ed, est, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hamming_decoder.md
HAMMING_DECODER -- requirements
Module: hamming_decoder

Interface
REQ-001 SHALL have port Clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port in_byte, input, 8: encoded byte; LSW first, then MSW.
REQ-004 SHALL have port in_valid, input, 1: in_byte valid.
REQ-005 SHALL have port in_ready, output, 1: block accepts in_byte this cycle.
REQ-006 SHALL have port out_data, output, 11: corrected data {b11..b1}.
REQ-007 SHALL have port out_status, output, 2: 00 clean, 01 single corrected, 10 double detected.
REQ-008 SHALL have port out_valid, output, 1: out_data/out_status valid.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-010 SHALL have ports corr_cnt and dbl_cnt, output, 8 each: error statistics (see Configuration).

Function
REQ-011 SHALL treat the word as 16 bits: LSW = {b4,b3,b2,p4,b1,p2,p1,p0}, MSW = {b11,b10,b9,b8,b7,b6,b5,p8}; bit position k (0..15) = {MSW,LSW}[k].
REQ-012 SHALL use even parity: pN covers positions whose index has bit N set; p0 makes all 16 bits even parity.
REQ-013 SHALL use FSM states GET_LO, GET_HI, CALC, SEND; reset state GET_LO.
REQ-014 in_ready SHALL be 1 only in GET_LO and GET_HI; a byte transfers when in_valid and in_ready are both 1.
REQ-015 GET_LO: on transfer, latch LSW, go to GET_HI; GET_HI: on transfer, latch MSW, go to CALC; without transfer, hold state.
REQ-016 CALC SHALL last exactly one cycle: compute syndrome s = {p8,p4,p2,p1} checks and overall parity pe = XOR of all 16 bits; register results; go to SEND.
REQ-017 Classification: s=0, pe=0 -> status 00; pe=1 -> flip bit position s (s=0 flips p0), status 01; s!=0, pe=0 -> no flip, status 10.
REQ-018 out_data SHALL be extracted from the corrected word (status 01) or the raw word (status 00, 10).
REQ-019 SEND: out_valid=1; out_data and out_status SHALL remain stable until out_ready=1; on that cycle return to GET_LO.
REQ-020 Latency: out_valid SHALL rise 2 cycles after the MSW transfer edge.
REQ-021 in_ready SHALL be 0 in CALC and SEND; no input is accepted while a result is pending.
REQ-022 out_data and out_status SHALL hold the last delivered values outside SEND.

Reset
REQ-023 Reset_n=0 SHALL asynchronously force state GET_LO, in_ready=0 while asserted, out_valid=0, out_data=0, out_status=00, latched bytes=0, corr_cnt=0, dbl_cnt=0.
REQ-024 Reset asserted in any state, including mid-word or in SEND, SHALL discard the partial word/result; after release the next accepted byte is treated as LSW.

Configuration
REQ-025 Macro DECODER_STATS_EN defined: corr_cnt SHALL increment on each delivered status 01 and dbl_cnt on each delivered status 10 (at the out_ready handshake), saturating at 8'hFF.
REQ-026 Macro DECODER_STATS_EN undefined: corr_cnt and dbl_cnt ports SHALL exist and be driven constant 0; no counter logic.

Verification
REQ-027 LSW 8'hFF, MSW 8'hFF, out_ready=1 -> out_data 11'h7FF, status 00, out_valid 2 cycles after MSW.
REQ-028 LSW 8'h20, MSW 8'h00 (b2 flipped) -> out_data 11'h000, status 01; corr_cnt 1 if DECODER_STATS_EN.
REQ-029 LSW 8'h00, MSW 8'h80 (b11 flipped) -> out_data 11'h000, status 01; LSW 8'h01 (p0 only) -> out_data 11'h000, status 01.
REQ-030 LSW 8'h03, MSW 8'h00 (p0,p1 flipped) -> status 10, out_data 11'h000; dbl_cnt 1 if DECODER_STATS_EN, 0 without.
REQ-031 Valid word with out_ready=0 for 3 cycles -> out_valid, out_data, out_status stable; in_ready=0 throughout; single handshake on out_ready=1.
REQ-032 Reset_n pulsed after LSW accepted -> outputs at reset values; next bytes 8'hFF, 8'hFF -> out_data 11'h7FF, status 00.
